// File: rtl/pattern_memory_mc.sv
// rtl/pattern_memory_mc.sv - dual-port pattern RAM: byte-strobed bus port, round-robin multi-channel read port
// Optional PATTERN_MEM_WSTRB_EN enables partial byte-strobe writes; default build accepts whole-word writes only.
module pattern_memory_mc #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DEPTH_WORDS = 16384,
  parameter int NUM_CH      = 2,
  parameter     INIT_FILE   = "font.hex"
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         request,
  input  logic [ADDR_WIDTH-1:0]        address,
  input  logic                         write,
  input  logic [3:0]                   wstrb,
  input  logic [31:0]                  wdata,
  output logic [31:0]                  rdata,
  output logic                         ack,
  output logic                         bus_error,
  input  logic [NUM_CH-1:0]            ch_req,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr,
  output logic [NUM_CH-1:0]            ch_gnt,
  output logic [NUM_CH-1:0]            ch_valid,
  output logic [NUM_CH*32-1:0]         ch_data
);

  localparam int IW = ADDR_WIDTH - 2;
  localparam int MW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CW-1:0] LAST_RST = CW'(NUM_CH - 1);

  logic [31:0] r_mem [DEPTH_WORDS];

  logic [IW-1:0]           w_a_idx;
  logic [MW-1:0]           w_a_widx;
  logic                    w_a_oor;
  logic                    w_a_reject;
  logic                    w_a_fault;
  logic                    w_a_we;
  logic [31:0]             r_a_q;
  logic                    r_ack;
  logic                    r_bus_error;

  logic [ADDR_WIDTH-1:0]   w_b_addr;
  logic [IW-1:0]           w_b_idx;
  logic [MW-1:0]           w_b_widx;
  logic                    w_b_oor;
  logic                    w_found;
  logic [CW-1:0]           w_win;
  logic [NUM_CH-1:0]       w_gnt;
  int                      w_best;
  logic [CW-1:0]           r_last;
  logic [31:0]             r_b_q;
  logic                    r_b_oor;
  logic [31:0]             w_b_word;
  logic [NUM_CH-1:0]       r_ch_valid;
  logic [NUM_CH*32-1:0]    r_hold;
  logic                    w_unused;

  assign w_a_idx  = address[ADDR_WIDTH-1:2];
  assign w_a_widx = w_a_idx[MW-1:0];
  assign w_a_oor  = (64'(w_a_idx) >= 64'(DEPTH_WORDS));

`ifdef PATTERN_MEM_WSTRB_EN
  assign w_a_reject = 1'b0;
`else
  assign w_a_reject = write && (wstrb != 4'hf);
`endif

  assign w_a_fault = w_a_oor | w_a_reject;
  assign w_a_we    = request & write & ~reset & ~w_a_fault;

  // Search begins one past the last winner so every requester is reached within NUM_CH cycles.
  always_comb begin
    w_found  = 1'b0;
    w_win    = '0;
    w_gnt    = '0;
    w_best   = NUM_CH;
    w_b_addr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      int d;
      d = (i + NUM_CH - 1 - int'(r_last)) % NUM_CH;
      if (ch_req[i] && (d < w_best)) begin
        w_best   = d;
        w_found  = 1'b1;
        w_win    = CW'(i);
        w_gnt    = '0;
        w_gnt[i] = 1'b1;
        w_b_addr = ch_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
    if (reset) begin
      w_found = 1'b0;
      w_gnt   = '0;
    end
  end

  assign ch_gnt   = w_gnt;
  assign w_b_idx  = w_b_addr[ADDR_WIDTH-1:2];
  assign w_b_widx = w_b_idx[MW-1:0];
  assign w_b_oor  = (64'(w_b_idx) >= 64'(DEPTH_WORDS));

  // Nonblocking reads on both ports give read-first behaviour, including the A-write/B-read collision.
  always_ff @(posedge clock) begin
    for (int b = 0; b < 4; b++) begin
      if (w_a_we && wstrb[b]) begin
        r_mem[w_a_widx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    r_a_q <= r_mem[w_a_widx];
    r_b_q <= r_mem[w_b_widx];
  end

  assign w_b_word = r_b_oor ? 32'h0 : r_b_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ack       <= 1'b0;
      r_bus_error <= 1'b0;
      r_ch_valid  <= '0;
      r_last      <= LAST_RST;
      r_b_oor     <= 1'b0;
      r_hold      <= '0;
    end else begin
      r_ack       <= request;
      r_bus_error <= request & w_a_fault;
      r_ch_valid  <= w_gnt;
      r_b_oor     <= w_b_oor;
      if (w_found) begin
        r_last <= w_win;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (r_ch_valid[i]) begin
          r_hold[i*32 +: 32] <= w_b_word;
        end
      end
    end
  end

  // The RAM output bypasses the hold register so data appears together with its valid pulse.
  always_comb begin
    ch_data = r_hold;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_ch_valid[i]) begin
        ch_data[i*32 +: 32] = w_b_word;
      end
    end
  end

  assign ch_valid  = r_ch_valid;
  assign ack       = r_ack;
  assign bus_error = r_bus_error;
  assign rdata     = (r_ack && !r_bus_error) ? r_a_q : 32'h0;

  assign w_unused = ^{address[1:0], w_b_addr[1:0]};

endmodule

// File: tb/tb_pattern_memory_mc.sv
// tb/tb_pattern_memory_mc.sv - scoreboard bench for pattern_memory_mc (NUM_CH=3, 64-word RAM)
module tb_pattern_memory_mc;
  localparam int AW    = 16;
  localparam int DEPTH = 64;
  localparam int NCH   = 3;
`ifdef PATTERN_MEM_WSTRB_EN
  localparam bit WSTRB_EN = 1'b1;
`else
  localparam bit WSTRB_EN = 1'b0;
`endif

  logic               clock;
  logic               reset;
  logic               request;
  logic [AW-1:0]      address;
  logic               write;
  logic [3:0]         wstrb;
  logic [31:0]        wdata;
  logic [31:0]        rdata;
  logic               ack;
  logic               bus_error;
  logic [NCH-1:0]     ch_req;
  logic [NCH*AW-1:0]  ch_addr;
  logic [NCH-1:0]     ch_gnt;
  logic [NCH-1:0]     ch_valid;
  logic [NCH*32-1:0]  ch_data;

  pattern_memory_mc #(
    .ADDR_WIDTH(AW), .DEPTH_WORDS(DEPTH), .NUM_CH(NCH), .INIT_FILE("")
  ) dut (
    .clock(clock), .reset(reset), .request(request), .address(address),
    .write(write), .wstrb(wstrb), .wdata(wdata), .rdata(rdata), .ack(ack),
    .bus_error(bus_error), .ch_req(ch_req), .ch_addr(ch_addr), .ch_gnt(ch_gnt),
    .ch_valid(ch_valid), .ch_data(ch_data)
  );

  typedef struct { int due; logic [31:0] rd; logic err; logic chk; } bus_exp_t;
  typedef struct { int due; int ch; logic [31:0] data; } ch_exp_t;
  typedef struct { logic wr; logic [15:0] ad; logic [3:0] sb; logic [31:0] wd; logic [31:0] rd; logic err; } vec_t;

  bus_exp_t       bq[$];
  ch_exp_t        cq[$];
  logic [31:0]    model [DEPTH];
  logic [31:0]    exp_hold [NCH];
  int             m_last = NCH - 1;
  logic [NCH-1:0] last_gnt;
  int             checks = 0;
  int             failures = 0;
  int             cyc = 0;
  logic           rst_s;
  vec_t           tbl [11];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc   <= cyc + 1;
    rst_s <= reset;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  bus_exp_t       m_be;
  ch_exp_t        m_ce;
  logic           m_exp_ack;
  logic [NCH-1:0] m_exp_v;

  always @(negedge clock) begin
    m_exp_ack = (bq.size() > 0) && (bq[0].due == cyc);
    chk("ack", 32'(ack), 32'(m_exp_ack));
    if (m_exp_ack) begin
      m_be = bq.pop_front();
      if (m_be.chk) chk("rdata", rdata, m_be.rd);
      chk("bus_error", 32'(bus_error), 32'(m_be.err));
    end else begin
      chk("rdata_idle", rdata, 32'h0);
      chk("bus_error_idle", 32'(bus_error), 32'h0);
    end
    if (rst_s) for (int i = 0; i < NCH; i++) exp_hold[i] = 32'h0;
    m_exp_v = '0;
    if ((cq.size() > 0) && (cq[0].due == cyc)) m_exp_v = NCH'(1 << cq[0].ch);
    chk("ch_valid", 32'(ch_valid), 32'(m_exp_v));
    if (m_exp_v != '0) begin
      m_ce = cq.pop_front();
      exp_hold[m_ce.ch] = m_ce.data;
    end
    for (int i = 0; i < NCH; i++) chk($sformatf("ch_data%0d", i), ch_data[i*32 +: 32], exp_hold[i]);
  end

  // One clock of stimulus; expectations are pushed from the bench model before the model absorbs any write.
  task automatic step(input logic rq, input logic wr, input logic [15:0] ad, input logic [3:0] sb,
                      input logic [31:0] wd, input logic [NCH-1:0] cr, input logic [NCH*AW-1:0] ca,
                      input logic rs, input logic use_exp, input logic [31:0] x_rd, input logic x_err,
                      input logic dchk);
    logic [NCH-1:0] eg;
    int             win;
    logic [15:0]    a;
    logic [13:0]    idx;
    logic           err;
    bus_exp_t       be;
    ch_exp_t        ce;
    @(negedge clock);
    reset = rs; request = rq; write = wr; address = ad; wstrb = sb; wdata = wd;
    ch_req = cr; ch_addr = ca;
    #1;
    eg = '0;
    win = 0;
    if (!rs) begin
      for (int k = 1; k <= NCH; k++) begin
        int c;
        c = (m_last + k) % NCH;
        if ((eg == '0) && cr[c[1:0]]) begin
          eg[c[1:0]] = 1'b1;
          win = c;
        end
      end
    end
    chk("ch_gnt", 32'(ch_gnt), 32'(eg));
    last_gnt = ch_gnt;
    if (rs) begin
      m_last = NCH - 1;
    end else if (eg != '0) begin
      a = ca[win*AW +: AW];
      idx = a[15:2];
      ce.due = cyc + 1;
      ce.ch = win;
      ce.data = (idx >= 14'(DEPTH)) ? 32'h0 : model[idx[5:0]];
      cq.push_back(ce);
      m_last = win;
    end
    if (rq && !rs) begin
      idx = ad[15:2];
      err = (idx >= 14'(DEPTH)) || (wr && !WSTRB_EN && (sb != 4'hf));
      be.due = cyc + 1;
      be.chk = dchk;
      if (use_exp) begin
        be.rd = x_rd;
        be.err = x_err;
      end else begin
        be.rd = err ? 32'h0 : model[idx[5:0]];
        be.err = err;
      end
      bq.push_back(be);
      if (wr && !err) begin
        for (int b = 0; b < 4; b++) if (sb[b]) model[idx[5:0]][8*b +: 8] = wd[8*b +: 8];
      end
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 16'h0, 4'h0, 32'h0, '0, '0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic chread(input logic [NCH-1:0] cr, input logic [NCH*AW-1:0] ca);
    step(1'b0, 1'b0, 16'h0, 4'h0, 32'h0, cr, ca, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  initial begin
    int          order [6];
    int          cw [NCH];
    logic [NCH*AW-1:0] ca;

    reset = 1'b1; request = 1'b0; write = 1'b0; address = '0; wstrb = '0; wdata = '0;
    ch_req = '0; ch_addr = '0;
    for (int i = 0; i < NCH; i++) exp_hold[i] = 32'h0;
    order = '{0, 1, 2, 0, 1, 2};

    tbl[0] = '{1'b1, 16'h0040, 4'hf, 32'hDEADBEEF, 32'hA5000010, 1'b0};
    tbl[1] = '{1'b0, 16'h0040, 4'h0, 32'h0,        32'hDEADBEEF, 1'b0};
    tbl[7] = '{1'b1, 16'h0100, 4'hf, 32'hFFFFFFFF, 32'h0,        1'b1};
    tbl[6] = '{1'b0, 16'h0100, 4'h0, 32'h0,        32'h0,        1'b1};
    tbl[8] = '{1'b0, 16'h0000, 4'h0, 32'h0,        32'hA5000000, 1'b0};
    tbl[9] = '{1'b0, 16'h00FC, 4'h0, 32'h0,        32'hA500003F, 1'b0};
`ifdef PATTERN_MEM_WSTRB_EN
    tbl[2]  = '{1'b1, 16'h0040, 4'b0001, 32'h000000AA, 32'hDEADBEEF, 1'b0};
    tbl[3]  = '{1'b0, 16'h0040, 4'h0,    32'h0,        32'hDEADBEAA, 1'b0};
    tbl[4]  = '{1'b1, 16'h0044, 4'b1010, 32'h11223344, 32'hA5000011, 1'b0};
    tbl[5]  = '{1'b0, 16'h0044, 4'h0,    32'h0,        32'h11003311, 1'b0};
    tbl[10] = '{1'b0, 16'h0043, 4'h0,    32'h0,        32'hDEADBEAA, 1'b0};
`else
    tbl[2]  = '{1'b1, 16'h0040, 4'b0001, 32'h000000AA, 32'h0,        1'b1};
    tbl[3]  = '{1'b0, 16'h0040, 4'h0,    32'h0,        32'hDEADBEEF, 1'b0};
    tbl[4]  = '{1'b1, 16'h0044, 4'b1010, 32'h11223344, 32'h0,        1'b1};
    tbl[5]  = '{1'b0, 16'h0044, 4'h0,    32'h0,        32'hA5000011, 1'b0};
    tbl[10] = '{1'b0, 16'h0043, 4'h0,    32'h0,        32'hDEADBEEF, 1'b0};
`endif

    // Reset held with live bus and channel traffic: nothing may be granted or acknowledged.
    for (int i = 0; i < 2; i++)
      step(1'b1, 1'b1, 16'h0000, 4'hf, 32'h12345678, 3'b111, '0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);

    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 1'b1, 16'(i * 4), 4'hf, 32'hA5000000 | 32'(i), '0, '0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    for (int i = 0; i < 11; i++)
      step(1'b1, tbl[i].wr, tbl[i].ad, tbl[i].sb, tbl[i].wd, '0, '0, 1'b0, 1'b1, tbl[i].rd, tbl[i].err, 1'b1);
    idle();

    cw = '{20, 30, 40};
    for (int k = 0; k < 6; k++) begin
      ca = {16'(cw[2] * 4), 16'(cw[1] * 4), 16'(cw[0] * 4)};
      chread(3'b111, ca);
      chk($sformatf("rr_order%0d", k), 32'(last_gnt), 32'(1 << order[k]));
      for (int i = 0; i < NCH; i++) if (last_gnt[i]) cw[i]++;
    end
    idle();

    step(1'b1, 1'b1, 16'h0014, 4'hf, 32'h5A5A0005, 3'b010, {16'h0, 16'h0014, 16'h0},
         1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    idle();
    chk("collision_old", ch_data[63:32], 32'hA5000005);
    chread(3'b010, {16'h0, 16'h0014, 16'h0});
    idle();
    chk("collision_new", ch_data[63:32], 32'h5A5A0005);

    step(1'b1, 1'b0, 16'h0100, 4'h0, 32'h0, 3'b001, {16'h0, 16'h0, 16'h0100},
         1'b0, 1'b1, 32'h0, 1'b1, 1'b1);
    idle();
    chk("ch_oor_data", ch_data[31:0], 32'h0);

    chread(3'b001, {16'h0, 16'h0, 16'h0008});
    step(1'b1, 1'b0, 16'h0040, 4'h0, 32'h0, 3'b001, {16'h0, 16'h0, 16'h0004},
         1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    chread(3'b111, {16'h00A0, 16'h0090, 16'h0080});
    chk("post_reset_gnt", 32'(last_gnt), 32'h1);
    idle();
    idle();
    idle();

    chk("bus_queue_drained", 32'(bq.size()), 32'h0);
    chk("ch_queue_drained", 32'(cq.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
